mmio_uart_ctrl: RTL and testbench
=================================

Name: mmio_uart_ctrl

Overview:
Memory-mapped I/O controller between the core's load/store stage and the on-chip uart. It decodes the 0x8000_xxxx I/O window and sequences the uart ready/valid handshakes. It buffers received bytes in a small FIFO and holds one pending transmit byte. It also provides cycle and retired-instruction counters for software benchmarking.

Parameters:
RX_FIFO_DEPTH, 8, receive FIFO entries; power of two, 2..64.
IO_BASE, 32'h8000_0000, base of I/O window; the decoder matches addr[31:28] against IO_BASE[31:28].

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
io_addr  in  32  byte address of load/store, word aligned
io_re  in  1  load strobe, one cycle per access
io_we  in  1  store strobe, one cycle per access; never asserted together with io_re
io_wdata  in  32  store data
io_rdata  out  32  load data, valid the cycle after io_re
inst_retire  in  1  pulses once per retired instruction
uart_tx_data  out  8  to uart data_in
uart_tx_valid  out  1  to uart data_in_valid
uart_tx_ready  in  1  from uart data_in_ready
uart_rx_data  in  8  from uart data_out
uart_rx_valid  in  1  from uart data_out_valid
uart_rx_ready  out  1  to uart data_out_ready

Behaviour:
- Register map, offset = io_addr[7:0]; accesses are ignored unless the window decode matches:
  - 0x00 STATUS (R): bit0 = tx_free, bit1 = rx_avail (FIFO not empty), bit2 = rx_overflow (sticky); all other bits 0.
  - 0x04 RXDATA (R): {24'b0, FIFO head}; the read pops the FIFO. Reading an empty FIFO returns 0 and does not pop.
  - 0x08 TXDATA (W): io_wdata[7:0] is queued for transmit.
  - 0x10 CYCLES (R): cycle counter.
  - 0x14 INSTRET (R): retired-instruction counter.
  - 0x18 CNTRST (W): any write clears both counters.
  - Unmapped reads return 0. Unmapped writes have no effect.
- Read latency is exactly 1 cycle: io_rdata is registered from the values present in the io_re cycle. io_rdata holds its value when there is no read.
- Read side effects (FIFO pop, clearing rx_overflow) commit at the io_re clock edge. Reading STATUS clears rx_overflow, but the returned value shows the pre-clear bit. If a new overflow occurs in the same cycle as the clearing read, the flag stays set.
- TX state machine, states IDLE and SEND:
  - IDLE: tx_free = 1, uart_tx_valid = 0. A TXDATA write latches the byte and moves to SEND.
  - SEND: uart_tx_valid = 1 and uart_tx_data is held stable. When uart_tx_valid and uart_tx_ready are both high at a clock edge, return to IDLE.
  - A TXDATA write while in SEND is dropped; the pending byte is unchanged.
  - A write in the same cycle as the SEND->IDLE handshake is also dropped, because tx_free was 0 in that cycle.
- RX FIFO:
  - uart_rx_ready = 1 at all times, so the uart never stalls.
  - A byte is pushed when uart_rx_valid = 1 and the FIFO is not full.
  - If the FIFO is full, the byte is discarded and rx_overflow is set.
  - Simultaneous push and pop on a full FIFO: the pop is performed first, the push succeeds, and there is no overflow.
  - Simultaneous push and pop on an empty FIFO: the read returns 0 and the pushed byte remains in the FIFO.
  - Pointers are log2(depth)+1 bits wide and wrap modulo 2*depth. Full and empty are derived from the pointer MSB and the lower bits.
- Counters: 32-bit, wrap from 0xFFFF_FFFF to 0.
  - CYCLES increments every cycle.
  - INSTRET increments when inst_retire = 1.
  - A CNTRST write has priority: both counters read 0 on the following cycle, and any increment in the write cycle is lost.
- Reset (asynchronous, any time): TX state IDLE, uart_tx_valid = 0, uart_tx_data = 0, FIFO empty, rx_overflow = 0, both counters = 0, io_rdata = 0, uart_rx_ready = 1. Reset during SEND abandons the pending byte.

Test Plan:
1. Release reset, read STATUS at cycle 5 -> io_rdata = 0x1 the next cycle. CYCLES read at cycle 10 returns 10 ±1; the bench checks the exact offset from its own cycle counter.
2. Write TXDATA 0x41 with uart_tx_ready held low for 20 cycles -> uart_tx_valid high and uart_tx_data = 0x41 throughout, STATUS bit0 = 0. A second write of 0x42 is dropped. Raise ready -> one handshake, then STATUS = 0x1.
3. Push bytes 0x10..0x17 via uart_rx_valid (depth 8), then a ninth byte 0x18 -> STATUS = 0x6. Eight RXDATA reads return 0x10..0x17 in order. A further STATUS read returns 0x0 (overflow already cleared by the first read).
4. With the FIFO full, pop and push 0x99 in the same cycle -> the read returns the head, there is no overflow, and 0x99 is the last byte read out.
5. Pulse inst_retire 37 times, read INSTRET -> 37. Write CNTRST, read both counters next -> INSTRET = 0, CYCLES = 1.
6. Assert rst asynchronously mid-cycle while in SEND with 3 bytes in the FIFO -> uart_tx_valid drops immediately. After release, STATUS = 0x1 and RXDATA reads 0.

Source files
------------

// File: rtl/mmio_uart_ctrl.sv
// MMIO bridge between the load/store stage and the uart: register decode, TX holding register,
// RX byte FIFO with sticky overflow, and cycle / retired-instruction counters.
module mmio_uart_ctrl #(
  parameter int unsigned RX_FIFO_DEPTH = 8,
  parameter logic [31:0] IO_BASE       = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] io_addr,
  input  logic        io_re,
  input  logic        io_we,
  input  logic [31:0] io_wdata,
  output logic [31:0] io_rdata,
  input  logic        inst_retire,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready
);

  localparam int unsigned AW = $clog2(RX_FIFO_DEPTH);
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  localparam logic [7:0] OffStatus  = 8'h00;
  localparam logic [7:0] OffRxData  = 8'h04;
  localparam logic [7:0] OffTxData  = 8'h08;
  localparam logic [7:0] OffCycles  = 8'h10;
  localparam logic [7:0] OffInstret = 8'h14;
  localparam logic [7:0] OffCntRst  = 8'h18;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StSend = 1'b1;

  logic       sel, rd, wr;
  logic [7:0] off;
  logic       unused_bits;

  assign sel         = io_addr[31:28] == IO_BASE[31:28];
  assign off         = io_addr[7:0];
  assign rd          = io_re && sel;
  assign wr          = io_we && sel;
  assign unused_bits = ^{io_addr[27:8], io_wdata[31:8]};

  // TX holding register
  logic [0:0] state_q, state_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_free;

  assign tx_free       = state_q == StIdle;
  assign uart_tx_valid = state_q == StSend;
  assign uart_tx_data  = tx_data_q;

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    case (state_q)
      StIdle: begin
        if (wr && off == OffTxData) begin
          tx_data_d = io_wdata[7:0];
          state_d   = StSend;
        end
      end
      StSend: begin
        if (uart_tx_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
    end
  end

  // RX FIFO; one extra pointer bit distinguishes full from empty
  logic [7:0] fifo_mem [RX_FIFO_DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic        fifo_empty, fifo_full, pop, push, ovf_set;
  logic        rx_overflow_q;
  logic [7:0]  head;

  assign uart_rx_ready = 1'b1;
  assign fifo_empty    = wptr_q == rptr_q;
  assign fifo_full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head          = fifo_mem[rptr_q[AW-1:0]];
  assign pop           = rd && off == OffRxData && !fifo_empty;
  // A pop on a full FIFO frees the slot the incoming byte lands in
  assign push          = uart_rx_valid && (!fifo_full || pop);
  assign ovf_set       = uart_rx_valid && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr_q[AW-1:0]] <= uart_rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      rx_overflow_q <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + PtrOne;
      if (pop)  rptr_q <= rptr_q + PtrOne;
      if (ovf_set)                       rx_overflow_q <= 1'b1;
      else if (rd && off == OffStatus)   rx_overflow_q <= 1'b0;
    end
  end

  // Benchmark counters
  logic [31:0] cycles_q, instret_q;
  logic        cnt_clr;

  assign cnt_clr = wr && off == OffCntRst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycles_q  <= 32'd0;
      instret_q <= 32'd0;
    end else if (cnt_clr) begin
      cycles_q  <= 32'd0;
      instret_q <= 32'd0;
    end else begin
      cycles_q <= cycles_q + 32'd1;
      if (inst_retire) instret_q <= instret_q + 32'd1;
    end
  end

  // Read data is registered and holds between reads
  logic [31:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (rd) begin
      case (off)
        OffStatus:  rdata_d = {29'b0, rx_overflow_q, !fifo_empty, tx_free};
        OffRxData:  rdata_d = fifo_empty ? 32'b0 : {24'b0, head};
        OffCycles:  rdata_d = cycles_q;
        OffInstret: rdata_d = instret_q;
        default:    rdata_d = 32'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= 32'b0;
    else     rdata_q <= rdata_d;
  end

  assign io_rdata = rdata_q;

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// Scoreboard bench for mmio_uart_ctrl: reads push expected data, a monitor checks io_rdata.
module tb_mmio_uart_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] io_addr, io_wdata, io_rdata;
  logic        io_re, io_we, inst_retire;
  logic [7:0]  uart_tx_data, uart_rx_data;
  logic        uart_tx_valid, uart_tx_ready, uart_rx_valid, uart_rx_ready;

  mmio_uart_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .io_addr       (io_addr),
    .io_re         (io_re),
    .io_we         (io_we),
    .io_wdata      (io_wdata),
    .io_rdata      (io_rdata),
    .inst_retire   (inst_retire),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_ready (uart_tx_ready),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_ready (uart_rx_ready)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] AStatus = 32'h8000_0000;
  localparam logic [31:0] ARx     = 32'h8000_0004;
  localparam logic [31:0] ATx     = 32'h8000_0008;
  localparam logic [31:0] ACyc    = 32'h8000_0010;
  localparam logic [31:0] AInst   = 32'h8000_0014;
  localparam logic [31:0] ACntRst = 32'h8000_0018;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          hs_cnt = 0;
  int          hs0;
  logic [31:0] held;

  always @(posedge clk) begin
    cyc    <= rst ? 0 : cyc + 1;
    hs_cnt <= hs_cnt + ((uart_tx_valid && uart_tx_ready) ? 1 : 0);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: every read strobe is followed by one registered io_rdata value
  always @(posedge clk) begin
    if (io_re) begin
      #1;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected read: got 0x%08h, expected no read", io_rdata);
      end else begin
        mon_e = exp_q.pop_front();
        check(mon_e.name, io_rdata, mon_e.val);
      end
    end
  end

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string nm);
    exp_q.push_back('{nm, e});
    io_addr = a;
    io_re   = 1'b1;
    @(negedge clk);
    io_re   = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    io_addr  = a;
    io_wdata = d;
    io_we    = 1'b1;
    @(negedge clk);
    io_we    = 1'b0;
  endtask

  task automatic rx(input logic [7:0] b);
    uart_rx_valid = 1'b1;
    uart_rx_data  = b;
    @(negedge clk);
    uart_rx_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    io_addr = '0; io_wdata = '0; io_re = 1'b0; io_we = 1'b0; inst_retire = 1'b0;
    uart_tx_ready = 1'b0; uart_rx_data = '0; uart_rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset io_rdata", io_rdata, 32'h0);
    check("reset tx_valid", {31'b0, uart_tx_valid}, 32'h0);
    check("reset tx_data", {24'b0, uart_tx_data}, 32'h0);
    check("reset rx_ready", {31'b0, uart_rx_ready}, 32'h1);
    rst = 1'b0;

    // 1: status and cycle counter after reset, window decode
    repeat (5) @(negedge clk);
    rd(AStatus, 32'h1, "status@5");
    repeat (4) @(negedge clk);
    held = cyc;
    rd(ACyc, held, "cycles@10");
    rd(32'h4000_0010, held, "outside window holds");
    rd(32'h8000_000C, 32'h0, "unmapped read");
    wr(32'h4000_0008, 32'h33);
    check("outside write no tx", {31'b0, uart_tx_valid}, 32'h0);

    // 2: TX held while uart stalls, dropped writes
    wr(ATx, 32'h41);
    for (int i = 0; i < 20; i++) begin
      check("tx_valid held", {31'b0, uart_tx_valid}, 32'h1);
      check("tx_data held", {24'b0, uart_tx_data}, 32'h41);
      if (i == 3)      rd(AStatus, 32'h0, "status tx busy");
      else if (i == 8) wr(ATx, 32'h42);
      else             @(negedge clk);
    end
    hs0 = hs_cnt;
    uart_tx_ready = 1'b1;
    wr(ATx, 32'h43);  // lands in the handshake cycle
    uart_tx_ready = 1'b0;
    check("tx idle after hs", {31'b0, uart_tx_valid}, 32'h0);
    @(negedge clk);
    check("write at hs dropped", {31'b0, uart_tx_valid}, 32'h0);
    check("one handshake", hs_cnt - hs0, 32'd1);
    rd(AStatus, 32'h1, "status tx free");

    // 3: fill FIFO and overflow, with TX kept busy so tx_free reads 0
    wr(ATx, 32'h5A);
    for (int i = 0; i < 9; i++) rx(8'(8'h10 + i));
    uart_rx_valid = 1'b1; uart_rx_data = 8'hEE;
    rd(AStatus, 32'h6, "status overflow");
    uart_rx_valid = 1'b0;
    rd(AStatus, 32'h6, "overflow re-set on clear");
    for (int i = 0; i < 8; i++) rd(ARx, 32'(8'h10 + i), "rx order");
    rd(AStatus, 32'h0, "status drained");

    // 4: pop+push on full, pop+push on empty
    for (int i = 0; i < 8; i++) rx(8'(8'h20 + i));
    uart_rx_valid = 1'b1; uart_rx_data = 8'h99;
    rd(ARx, 32'h20, "pop+push full");
    uart_rx_valid = 1'b0;
    rd(AStatus, 32'h2, "no overflow");
    for (int i = 1; i < 8; i++) rd(ARx, 32'(8'h20 + i), "rx after refill");
    rd(ARx, 32'h99, "last is 0x99");
    rd(ARx, 32'h0, "empty read");
    uart_rx_valid = 1'b1; uart_rx_data = 8'h77;
    rd(ARx, 32'h0, "pop+push empty");
    uart_rx_valid = 1'b0;
    rd(AStatus, 32'h2, "byte kept");
    rd(ARx, 32'h77, "kept byte");
    uart_tx_ready = 1'b1;
    @(negedge clk);
    uart_tx_ready = 1'b0;
    rd(AStatus, 32'h1, "status idle");

    // 5: instret and counter clear
    for (int i = 0; i < 37; i++) begin
      inst_retire = 1'b1;
      @(negedge clk);
      inst_retire = 1'b0;
      @(negedge clk);
    end
    rd(AInst, 32'd37, "instret 37");
    inst_retire = 1'b1;
    wr(ACntRst, 32'h0);
    inst_retire = 1'b0;
    rd(AInst, 32'd0, "instret cleared");
    rd(ACyc, 32'd1, "cycles after clear");

    // 6: asynchronous reset during SEND with bytes queued
    wr(ATx, 32'hA5);
    for (int i = 0; i < 3; i++) rx(8'(8'h30 + i));
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async rst tx_valid", {31'b0, uart_tx_valid}, 32'h0);
    check("async rst io_rdata", io_rdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst tx_data", {24'b0, uart_tx_data}, 32'h0);
    rd(AStatus, 32'h1, "status after rst");
    rd(ARx, 32'h0, "rx empty after rst");

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL pending reads: got %0d outstanding, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
